// File: rtl/counter_mod.sv
// Registered modulo up/down counter with signed net stepping and a same-cycle next-value output.
// Build option: define COUNTER_SATURATE_EN to saturate at 0/MAX_VALUE instead of wrapping.
module counter_mod #(
  parameter int WIDTH      = 4,
  parameter int STEP_WIDTH = 2,
  parameter int MAX_VALUE  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reinit,
  input  logic [WIDTH-1:0]      initial_value,
  input  logic                  incr_valid,
  input  logic [STEP_WIDTH-1:0] incr,
  input  logic                  decr_valid,
  input  logic [STEP_WIDTH-1:0] decr,
  output logic [WIDTH-1:0]      value,
  output logic [WIDTH-1:0]      value_next
);

  // Two spare bits over the widest operand keep value+inc-dec exact and signed.
  localparam int TW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 2;

  localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX_VALUE);
  localparam logic signed [TW-1:0] MAX_T = TW'(MAX_VALUE);
  localparam logic signed [TW-1:0] MOD_T = TW'(MAX_VALUE + 1);

  logic signed [TW-1:0] inc_ext;
  logic signed [TW-1:0] dec_ext;
  logic signed [TW-1:0] t_raw;
  logic signed [TW-1:0] t_fix;
  logic [WIDTH-1:0]     load_value;

  always_comb begin
    inc_ext    = '0;
    dec_ext    = '0;
    t_raw      = '0;
    t_fix      = '0;
    load_value = '0;
    value_next = '0;

    if (incr_valid) inc_ext = TW'(incr);
    if (decr_valid) dec_ext = TW'(decr);

    t_raw = TW'(value) + inc_ext - dec_ext;
    t_fix = t_raw;

`ifdef COUNTER_SATURATE_EN
    if (t_raw > MAX_T)
      t_fix = MAX_T;
    else if (t_raw < 0)
      t_fix = '0;
`else
    // A single correction is enough since a step never exceeds MAX_VALUE.
    if (t_raw > MAX_T)
      t_fix = t_raw - MOD_T;
    else if (t_raw < 0)
      t_fix = t_raw + MOD_T;
`endif

    load_value = (initial_value > MAX_W) ? MAX_W : initial_value;

    if (reinit)
      value_next = load_value;
    else
      value_next = WIDTH'(t_fix);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      value <= '0;
    else
      value <= value_next;
  end

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: a reference model feeds a scoreboard queue of expected counts.
// Honours COUNTER_SATURATE_EN so the same bench covers both builds.
module tb_counter_mod;

  localparam int WIDTH      = 4;
  localparam int STEP_WIDTH = 2;
  localparam int MAX_VALUE  = 10;

  logic                  clk;
  logic                  rst;
  logic                  reinit;
  logic [WIDTH-1:0]      initial_value;
  logic                  incr_valid;
  logic [STEP_WIDTH-1:0] incr;
  logic                  decr_valid;
  logic [STEP_WIDTH-1:0] decr;
  logic [WIDTH-1:0]      value;
  logic [WIDTH-1:0]      value_next;

  int checks = 0;
  int errors = 0;
  int model_val = 0;
  int exp_q[$];

  counter_mod #(
    .WIDTH(WIDTH),
    .STEP_WIDTH(STEP_WIDTH),
    .MAX_VALUE(MAX_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reinit(reinit),
    .initial_value(initial_value),
    .incr_valid(incr_valid),
    .incr(incr),
    .decr_valid(decr_valid),
    .decr(decr),
    .value(value),
    .value_next(value_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_next(int cur, bit ri, int init, bit iv, int inc, bit dv, int dec);
    int t;
    if (ri) return (init > MAX_VALUE) ? MAX_VALUE : init;
    t = cur + (iv ? inc : 0) - (dv ? dec : 0);
`ifdef COUNTER_SATURATE_EN
    if (t > MAX_VALUE) t = MAX_VALUE;
    else if (t < 0) t = 0;
`else
    if (t > MAX_VALUE) t = t - (MAX_VALUE + 1);
    else if (t < 0) t = t + (MAX_VALUE + 1);
`endif
    return t;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check the combinational next value, then the registered result.
  task automatic applyStimulus(input string tag, input bit ri, input int init,
                               input bit iv, input int inc, input bit dv, input int dec);
    int exp_val;
    @(negedge clk);
    reinit        = ri;
    initial_value = WIDTH'(init);
    incr_valid    = iv;
    incr          = STEP_WIDTH'(inc);
    decr_valid    = dv;
    decr          = STEP_WIDTH'(dec);
    #1;
    exp_val = model_next(model_val, ri, init, iv, inc, dv, dec);
    checkOutput({tag, "_next"}, int'(value_next), exp_val);
    exp_q.push_back(exp_val);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue"}, 0, 1);
    end else begin
      exp_val = exp_q.pop_front();
      checkOutput({tag, "_value"}, int'(value), exp_val);
      model_val = exp_val;
    end
  endtask

  initial begin
    rst           = 1'b1;
    reinit        = 1'b0;
    initial_value = '0;
    incr_valid    = 1'b0;
    incr          = '0;
    decr_valid    = 1'b0;
    decr          = '0;

    // Reset takes effect before the first clock edge.
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_value", int'(value), 0);
    incr_valid = 1'b1;
    incr       = 2'd2;
    #1;
    checkOutput("reset_next_comb", int'(value_next), 2);
    incr_valid = 1'b0;
    incr       = '0;

    @(negedge clk);
    rst = 1'b1;
    model_val = 0;

    applyStimulus("reinit4", 1, 4, 0, 0, 0, 0);
    applyStimulus("idle4",   0, 0, 0, 0, 0, 0);
    applyStimulus("incr2",   0, 0, 1, 2, 0, 0);
    applyStimulus("decr1",   0, 0, 0, 0, 1, 1);
    applyStimulus("net32",   0, 0, 1, 3, 1, 2);

    applyStimulus("reinit9", 1, 9, 0, 0, 0, 0);
    applyStimulus("ovf",     0, 0, 1, 3, 0, 0);
    applyStimulus("reinit1", 1, 1, 0, 0, 0, 0);
    applyStimulus("unf",     0, 0, 0, 0, 1, 3);

    applyStimulus("reinit7", 1, 7, 0, 0, 0, 0);
    applyStimulus("reprio",  1, 2, 1, 2, 1, 1);
    applyStimulus("clamp15", 1, 15, 1, 1, 0, 0);
    applyStimulus("max_inc", 0, 0, 1, 1, 0, 0);
    applyStimulus("reinit0", 1, 0, 0, 0, 0, 0);
    applyStimulus("zero_dec", 0, 0, 0, 0, 1, 1);
    applyStimulus("inv_step", 0, 0, 0, 3, 0, 3);

    for (int i = 0; i < 3; i++)
      applyStimulus("hold", 0, 0, 0, 1, 0, 2);

    for (int i = 0; i < 40; i++)
      applyStimulus("rand", ($urandom_range(0, 9) == 0), $urandom_range(0, 15),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3));

    applyStimulus("reinit6", 1, 6, 0, 0, 0, 0);

    // Mid-cycle reset with a pending step and a reinit request.
    @(negedge clk);
    incr_valid    = 1'b1;
    incr          = 2'd3;
    reinit        = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_value", int'(value), 0);
    checkOutput("async_rst_next", int'(value_next), 3);
    reinit        = 1'b1;
    initial_value = 4'd5;
    @(posedge clk);
    #1;
    checkOutput("rst_dominates", int'(value), 0);
    @(negedge clk);
    rst        = 1'b1;
    reinit     = 1'b0;
    incr_valid = 1'b0;
    incr       = '0;
    exp_q.delete();
    model_val = 0;

    applyStimulus("post_rst", 0, 0, 1, 2, 0, 0);
    applyStimulus("post_dec", 0, 0, 0, 0, 1, 3);

    if (exp_q.size() != 0)
      checkOutput("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
